// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one SPI master between NUM_REQ requesters.
// It serialises whole words, returns each read-back word to its owner and bounds every transfer with a timeout.
module spi_master_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned SPI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic [NUM_REQ-1:0]                  i_req_valid,
  input  logic [NUM_REQ*SPI_DATA_WIDTH-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]                  o_req_ready,
  output logic [NUM_REQ-1:0]                  o_rsp_done,
  output logic [SPI_DATA_WIDTH-1:0]           o_rsp_data,
  output logic                                o_rsp_error,
  output logic [2:0]                          o_grant_id,
  output logic                                o_busy,
  output logic                                o_enable,
  output logic [SPI_DATA_WIDTH-1:0]           o_data,
  input  logic                                i_done,
  input  logic                                i_busy,
  input  logic [SPI_DATA_WIDTH-1:0]           i_data
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    GAP       = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          last_grant_q, last_grant_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      enable_q, enable_d;
  logic [SPI_DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_REQ-1:0]        ready_q, ready_d;
  logic [NUM_REQ-1:0]        rsp_done_q, rsp_done_d;
  logic [SPI_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                      rsp_error_q, rsp_error_d;
  logic [2:0]                grant_q, grant_d;
  logic                      busy_q, busy_d;

  logic [SPI_DATA_WIDTH-1:0] req_word [NUM_REQ];
  logic                      win_found;
  logic [IDX_W-1:0]          win_idx;
  logic [IDX_W-1:0]          cand_idx;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_word
    assign req_word[k] = i_req_data[k*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
  end

  // Search downwards from the farthest candidate so the nearest one after last_grant wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      cand_idx = IDX_W'((32'(last_grant_q) + i) % NUM_REQ);
      if (i_req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    enable_d     = enable_q;
    data_d       = data_q;
    grant_d      = grant_q;
    ready_d      = '0;
    rsp_done_d   = '0;
    rsp_data_d   = '0;
    rsp_error_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          data_d           = req_word[win_idx];
          enable_d         = 1'b1;
          ready_d[win_idx] = 1'b1;
          grant_d          = 3'(win_idx);
          last_grant_d     = win_idx;
          cnt_d            = '0;
          state_d          = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion on the timeout cycle takes precedence over the error.
        if (i_done) begin
          enable_d                 = 1'b0;
          rsp_done_d[last_grant_q] = 1'b1;
          rsp_data_d               = i_data;
          state_d                  = GAP;
        end else if (TO_EN && (cnt_q == CNT_W'(TO_LAST))) begin
          enable_d                 = 1'b0;
          rsp_done_d[last_grant_q] = 1'b1;
          rsp_error_d              = 1'b1;
          state_d                  = GAP;
        end
      end
      GAP: begin
        enable_d = 1'b0;
        if (!i_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        enable_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      enable_q     <= 1'b0;
      data_q       <= '0;
      ready_q      <= '0;
      rsp_done_q   <= '0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      enable_q     <= enable_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      rsp_done_q   <= rsp_done_d;
      rsp_data_q   <= rsp_data_d;
      rsp_error_q  <= rsp_error_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
    end
  end

  assign o_enable    = enable_q;
  assign o_data      = data_q;
  assign o_req_ready = ready_q;
  assign o_rsp_done  = rsp_done_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_error = rsp_error_q;
  assign o_grant_id  = grant_q;
  assign o_busy      = busy_q;

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Round-robin arbiter and sequencer that shares one SPI master between `NUM_REQ` independent requesters, such as the codec configuration driver and a runtime volume/mute controller. It sits between the requesters and the SPI master control port (`o_enable`/`o_data` out, `i_done`/`i_busy`/`i_data` in). It serialises whole SPI words, routes each read-back word to its owner, and bounds every transfer with a timeout.

## Interface
- `NUM_REQ`, 2: number of requesters; legal range 2..8.
- `SPI_DATA_WIDTH`, 32: SPI word width; must match the SPI master.
- `TIMEOUT_CYCLES`, 4096: maximum number of cycles in `WAIT_DONE` before a transfer is abandoned; 0 disables the timeout.

Ports:
- `i_clock`  in  1  single clock; all logic on the rising edge.
- `i_reset`  in  1  synchronous, active-low reset.
- `i_req_valid`  in  NUM_REQ  per-requester request; held with data until `o_req_ready[k]`.
- `i_req_data`  in  NUM_REQ*SPI_DATA_WIDTH  per-requester word; requester k occupies bits [k*W +: W].
- `o_req_ready`  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- `o_rsp_done`  out  NUM_REQ  one-cycle completion pulse to the owner of the transfer.
- `o_rsp_data`  out  SPI_DATA_WIDTH  read-back word; valid only while any `o_rsp_done` bit is high.
- `o_rsp_error`  out  1  high together with `o_rsp_done` when the transfer timed out.
- `o_grant_id`  out  3  index of the current or most recent owner.
- `o_busy`  out  1  high in every state except `IDLE`.
- `o_enable`  out  1  SPI master start/hold.
- `o_data`  out  SPI_DATA_WIDTH  word to the SPI master.
- `i_done`  in  1  SPI master completion pulse.
- `i_busy`  in  1  SPI master busy.
- `i_data`  in  SPI_DATA_WIDTH  SPI master read-back word.

## Operation
- The state machine has three states: `IDLE`, `WAIT_DONE` and `GAP`.
- **`IDLE`** with any `i_req_valid` set:
  - Select the winner by round-robin, starting the search at `last_grant+1` and wrapping modulo `NUM_REQ`.
  - Register `o_data <= i_req_data[g]`, `o_enable <= 1`, `o_req_ready[g] <= 1` (a single-cycle pulse), `o_grant_id <= g`, `last_grant <= g`.
  - Go to `WAIT_DONE` and clear the timeout counter.
- **`WAIT_DONE`**:
  - `o_enable` and `o_data` are held constant and the counter increments every cycle.
  - On `i_done=1`: `o_enable <= 0`, `o_rsp_done[g] <= 1`, `o_rsp_data <= i_data`, `o_rsp_error <= 0`, go to `GAP`.
  - When the counter reaches `TIMEOUT_CYCLES-1` with no `i_done`: `o_enable <= 0`, `o_rsp_done[g] <= 1`, `o_rsp_data <= 0`, `o_rsp_error <= 1`, go to `GAP`.
  - If `i_done` and the timeout occur in the same cycle, `i_done` wins and there is no error.
- **`GAP`**:
  - `o_enable` stays 0 and `o_rsp_*` return to 0.
  - Go to `IDLE` only when `i_busy=0`; otherwise remain in `GAP`.
- **Requester rules**:
  - A requester may drop `i_req_valid` at any time before it sees `o_req_ready`; a dropped request is simply never granted.
  - `i_req_data` is captured only on the grant edge.
  - A requester is not re-granted while its own transfer is outstanding, because grants occur only in `IDLE`.
- **Fairness**: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than `NUM_REQ-1` transfers.
- **`i_done` outside `WAIT_DONE`** is ignored.
- **Reset** (`i_reset=0` at an edge, including mid-transfer):
  - State goes to `IDLE` and `last_grant` goes to `NUM_REQ-1`, so requester 0 has first priority.
  - All outputs go to 0: `o_enable`, `o_data`, `o_req_ready`, `o_rsp_done`, `o_rsp_data`, `o_rsp_error`, `o_grant_id`, `o_busy`.
  - The counter is cleared.
  - No `o_rsp_done` is issued for an aborted transfer.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Grant latency:
  - `i_req_valid` sampled high in `IDLE` at edge E0.
  - After E0, `o_enable=1`, `o_data` is valid and `o_req_ready[g]=1`.
  - `o_req_ready[g]` is 0 again after E0+1.
- Completion latency:
  - `i_done` sampled at edge E1.
  - After E1, `o_enable=0` and `o_rsp_done[g]=1` with `o_rsp_data`, for exactly one cycle.
- Back-to-back spacing: `o_enable` is low for at least 2 cycles (`GAP` + `IDLE`) between words. The SPI master always sees a falling edge of `o_enable`.
- Timeout: `o_rsp_error` is asserted `TIMEOUT_CYCLES` cycles after `o_enable` rose.

## Test plan
- **Reset values**: hold `i_reset=0` for 3 cycles with all requests high -> every output is 0 and there is no `o_req_ready`. Release reset -> the first grant goes to requester 0.
- **Single transfer**: requester 1 requests `0x00400007`, and the master model pulses `i_done` 20 cycles later with `i_data=0x000000A5`.
  - `o_req_ready[1]` pulses once, and `o_data=0x00400007` with `o_enable` high for 20 cycles.
  - Then `o_rsp_done[1]` pulses with `o_rsp_data=0x000000A5` and `o_rsp_error=0`.
- **Round-robin**: `NUM_REQ=2`, both requesters continuously valid for 6 transfers -> grant order is 0,1,0,1,0,1, and each inter-word `o_enable` low gap is ≥2 cycles.
- **Timeout**: `TIMEOUT_CYCLES=16` and the master never asserts `i_done`.
  - `o_enable` drops exactly 16 cycles after rising.
  - `o_rsp_done[g]=1`, `o_rsp_error=1`, `o_rsp_data=0`, and the next request is then granted normally.
- **Boundary cases**:
  - `i_done` on the timeout cycle -> no error.
  - `i_busy` held high 5 cycles after `i_done` -> the arbiter stays in `GAP` for 5 cycles.
  - Reset asserted mid-`WAIT_DONE` -> `o_enable` is 0 next cycle and no `o_rsp_done` is issued.
